// File: rtl/gpr_file_pkg.sv
// Shared types and index helpers for the multi-ported GPR file.
// Packed port buses are sliced with the helpers below.
package gpr_file_pkg;

  localparam int LANE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } init_state_e;

  function automatic int bytes_of(input int data_w);
    return data_w / LANE_W;
  endfunction

  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic int lane_lsb(input int lane);
    return lane * LANE_W;
  endfunction

endpackage

// File: rtl/gpr_init_fsm.sv
// Sequential clear engine: walks every entry once after reset or a clear request.
// It holds busy high until the walk reaches the last entry.
module gpr_init_fsm
  import gpr_file_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  init_state_e       state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              busy_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_INIT;
      ptr_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      case (state_reg)
        ST_INIT: begin
          ptr_reg <= ptr_reg + ADDR_W'(1);
          if (ptr_reg == {ADDR_W{1'b1}}) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          if (clear_req) begin
            state_reg <= ST_INIT;
            ptr_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
      endcase
    end
  end

  // No entry is touched while reset is held, so the clear strobe is gated by rst.
  assign clr_en   = rst & (state_reg == ST_INIT);
  assign clr_addr = ptr_reg;
  assign busy     = busy_reg;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-ported GPR array with byte-lane writes, optional write-to-read bypass
// and an optional hardwired-zero entry 0.
module gpr_file_mp
  import gpr_file_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD*ADDR_W-1:0]        rd_addr,
  output logic [NUM_RD*DATA_W-1:0]        rd_data,
  input  logic [NUM_WR-1:0]               wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]        wr_addr,
  input  logic [NUM_WR*(DATA_W/8)-1:0]    wr_be,
  input  logic [NUM_WR*DATA_W-1:0]        wr_data,
  input  logic                            clear_req,
  output logic                            busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BYTES = bytes_of(DATA_W);

  logic [DATA_W-1:0] mem_reg  [DEPTH];
  logic [DATA_W-1:0] mem_next [DEPTH];

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;

  logic [ADDR_W-1:0] wr_addr_a [NUM_WR];
  logic [BYTES-1:0]  wr_be_a   [NUM_WR];
  logic [DATA_W-1:0] wr_data_a [NUM_WR];
  logic [NUM_WR-1:0] wr_act;

  gpr_init_fsm #(
    .ADDR_W (ADDR_W)
  ) u_init (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
      assign wr_addr_a[gi] = wr_addr[slice_lsb(gi, ADDR_W) +: ADDR_W];
      assign wr_be_a[gi]   = wr_be[slice_lsb(gi, BYTES) +: BYTES];
      assign wr_data_a[gi] = wr_data[slice_lsb(gi, DATA_W) +: DATA_W];
      // A write aimed at the hardwired-zero entry behaves as if never issued.
      assign wr_act[gi]    = wr_en[gi] & ~((ZERO_REG != 0) && (wr_addr_a[gi] == '0));
    end
  endgenerate

  // Ports are applied in ascending order so the highest port owns each contested lane.
  always_comb begin
    mem_next = mem_reg;
    if (clr_en) begin
      mem_next[clr_addr] = '0;
    end else if (rst && !busy) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_act[w]) begin
          for (int b = 0; b < BYTES; b++) begin
            if (wr_be_a[w][b]) begin
              mem_next[wr_addr_a[w]][lane_lsb(b) +: LANE_W] = wr_data_a[w][lane_lsb(b) +: LANE_W];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_reg <= mem_next;
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] raddr;
      logic [DATA_W-1:0] word;

      assign raddr = rd_addr[slice_lsb(gi, ADDR_W) +: ADDR_W];

      always_comb begin
        word = mem_reg[raddr];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WR; w++) begin
            for (int b = 0; b < BYTES; b++) begin
              if (wr_act[w] && wr_be_a[w][b] && (wr_addr_a[w] == raddr)) begin
                word[lane_lsb(b) +: LANE_W] = wr_data_a[w][lane_lsb(b) +: LANE_W];
              end
            end
          end
        end
        if (busy || ((ZERO_REG != 0) && (raddr == '0))) begin
          word = '0;
        end
      end

      assign rd_data[slice_lsb(gi, DATA_W) +: DATA_W] = word;
    end
  endgenerate

endmodule

// File: tb/tb_gpr_file_mp.sv
// Randomised scoreboard bench for gpr_file_mp: one bypassing and one
// non-bypassing instance share stimulus and are checked against an array model.
module tb_gpr_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NR*AW-1:0]    rd_addr;
  logic [NW-1:0]       wr_en;
  logic [NW*AW-1:0]    wr_addr;
  logic [NW*NB-1:0]    wr_be;
  logic [NW*DW-1:0]    wr_data;
  logic                clear_req;
  logic [NR*DW-1:0]    rd_data_byp;
  logic [NR*DW-1:0]    rd_data_nob;
  logic                busy_byp;
  logic                busy_nob;

  gpr_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1), .BYPASS(1)
  ) dut_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_byp),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .clear_req(clear_req), .busy(busy_byp)
  );

  gpr_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1), .BYPASS(0)
  ) dut_nob (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nob),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .clear_req(clear_req), .busy(busy_nob)
  );

  typedef struct {
    logic           busy;
    logic [NR*DW-1:0] rd_byp;
    logic [NR*DW-1:0] rd_nob;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  e_cur;
  string t_cur;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Reference model: register contents plus the number of clear steps still owed.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_busy = 1'b1;
  int            m_left = DEPTH;

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] addr, input bit byp);
    logic [DW-1:0] w;
    if (m_busy || addr == '0) return '0;
    w = ref_mem[addr];
    if (byp) begin
      for (int p = 0; p < NW; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] == addr)
          for (int b = 0; b < NB; b++)
            if (wr_be[p*NB + b]) w[b*8 +: 8] = wr_data[p*DW + b*8 +: 8];
    end
    return w;
  endfunction

  task automatic model_edge();
    if (!rst) begin
      m_busy = 1'b1;
      m_left = DEPTH;
    end else if (m_busy) begin
      ref_mem[DEPTH - m_left] = '0;
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] != '0)
          for (int b = 0; b < NB; b++)
            if (wr_be[p*NB + b])
              ref_mem[wr_addr[p*AW +: AW]][b*8 +: 8] = wr_data[p*DW + b*8 +: 8];
      end
      if (clear_req) begin
        m_busy = 1'b1;
        m_left = DEPTH;
      end
    end
  endtask

  task automatic step(input string tag);
    exp_t e;
    e.busy = m_busy;
    for (int r = 0; r < NR; r++) begin
      e.rd_byp[r*DW +: DW] = exp_read(rd_addr[r*AW +: AW], 1'b1);
      e.rd_nob[r*DW +: DW] = exp_read(rd_addr[r*AW +: AW], 1'b0);
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en     = '0;
    wr_addr   = '0;
    wr_be     = '0;
    wr_data   = '0;
    clear_req = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    wr_en[p]              = 1'b1;
    wr_addr[p*AW +: AW]   = a;
    wr_be[p*NB +: NB]     = be;
    wr_data[p*DW +: DW]   = d;
  endtask

  task automatic cmp(input string tag, input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s actual=%h required=%h", tag, nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      t_cur = tag_q.pop_front();
      txn++;
      cmp(t_cur, "busy_byp", {63'b0, busy_byp}, {63'b0, e_cur.busy});
      cmp(t_cur, "busy_nob", {63'b0, busy_nob}, {63'b0, e_cur.busy});
      cmp(t_cur, "rd0_byp", {32'b0, rd_data_byp[DW-1:0]},    {32'b0, e_cur.rd_byp[DW-1:0]});
      cmp(t_cur, "rd1_byp", {32'b0, rd_data_byp[2*DW-1:DW]}, {32'b0, e_cur.rd_byp[2*DW-1:DW]});
      cmp(t_cur, "rd0_nob", {32'b0, rd_data_nob[DW-1:0]},    {32'b0, e_cur.rd_nob[DW-1:0]});
      cmp(t_cur, "rd1_nob", {32'b0, rd_data_nob[2*DW-1:DW]}, {32'b0, e_cur.rd_nob[2*DW-1:DW]});
      $display("txn %0d %s rd_addr=%h busy=%0d rd_byp=%h rd_nob=%h",
               txn, t_cur, rd_addr, busy_byp, rd_data_byp, rd_data_nob);
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rst     = 1'b0;
    rd_addr = {5'd5, 5'd5};
    idle_inputs();
    @(posedge clk);
    model_edge();
    #1;
    repeat (2) step("reset");

    rst = 1'b1;
    repeat (34) step("init");

    for (int a = 0; a < DEPTH; a += 2) begin
      rd_addr = {AW'(a + 1), AW'(a)};
      step("sweep");
    end

    rd_addr = {5'd3, 5'd3};
    wr(0, 5'd3, 32'hDEADBEEF, 4'hF);
    step("wr3_full");
    idle_inputs();
    wr(0, 5'd3, 32'h0000AA00, 4'h2);
    step("wr3_lane1");
    idle_inputs();
    step("rd3");

    rd_addr = {5'd7, 5'd7};
    wr(0, 5'd7, 32'h11111111, 4'hF);
    wr(1, 5'd7, 32'h22222222, 4'h3);
    step("collide7");
    idle_inputs();
    step("rd7");

    rd_addr = {5'd3, 5'd9};
    wr(0, 5'd9, 32'hCAFE0001, 4'hF);
    step("byp9");
    idle_inputs();
    step("rd9");

    rd_addr = {5'd0, 5'd0};
    wr(0, 5'd0, 32'hFFFFFFFF, 4'hF);
    wr(1, 5'd0, 32'hFFFFFFFF, 4'hF);
    step("zero_wr");
    idle_inputs();
    step("zero_rd");

    rd_addr   = {5'd7, 5'd3};
    clear_req = 1'b1;
    step("clear_req");
    clear_req = 1'b0;
    repeat (10) step("clear_run");
    rst = 1'b0;
    step("rst_mid");
    rst = 1'b1;
    repeat (34) step("reinit");
    rd_addr = {5'd9, 5'd3};
    step("rd3_cleared");

    for (int n = 0; n < 300; n++) begin
      rst       = ($urandom_range(0, 199) != 0);
      clear_req = ($urandom_range(0, 63) == 0);
      wr_en     = NW'($urandom);
      for (int p = 0; p < NW; p++) begin
        wr_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
        wr_be[p*NB +: NB]   = NB'($urandom);
        wr_data[p*DW +: DW] = $urandom;
      end
      for (int r = 0; r < NR; r++) begin
        if ($urandom_range(0, 1) == 1)
          rd_addr[r*AW +: AW] = wr_addr[$urandom_range(0, NW-1)*AW +: AW];
        else
          rd_addr[r*AW +: AW] = AW'($urandom_range(0, 7));
      end
      step("rand");
    end

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    #1;
    cmp("end", "queue_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
